// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command receiver (sync byte, parser states, error codes).
// CMD_CHECKSUM_EN adds the CSUM parser state.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [1:0] ERR_FRAMING = 2'd0;
    localparam logic [1:0] ERR_ADDR    = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
`ifdef CMD_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_WRITE
    } parser_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic [3:0]  addr;
        logic [31:0] data;
    } cmd_t;

    // Upper nibble must be clear and the index must name an existing register.
    function automatic logic addr_ok(input logic [7:0] b, input int num_regs);
        return (b[7:4] == 4'd0) && (int'(b[3:0]) < num_regs);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// Purpose: 8N1 UART byte receiver with 2-flop synchroniser, start-glitch rejection and stop-bit check.
// Latency: byte_valid/frame_err pulse one cycle after the stop-bit sample.
// Backpressure: none; the consumer must accept every one-cycle strobe.
module uart_rx_byte
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF_C = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] DIV_C  = CW'(BAUD_DIV);

    logic            rx_meta;
    logic            rx_sync;
    logic            rx_prev;
    rx_state_t       state;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rx_sync && rx_prev) begin
                        state <= RX_START;
                        cnt   <= CW'(1);
                    end
                end
                RX_START: begin
                    // A start bit that is high again at mid-bit was line noise.
                    if (cnt == HALF_C) begin
                        if (!rx_sync) begin
                            state   <= RX_DATA;
                            cnt     <= CW'(1);
                            bit_idx <= '0;
                        end else begin
                            state <= RX_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == DIV_C) begin
                        shift <= {rx_sync, shift[7:1]};
                        cnt   <= CW'(1);
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == DIV_C) begin
                        state <= RX_IDLE;
                        if (rx_sync) begin
                            rx_byte    <= shift;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_cmd_rx.sv
// Purpose: UART command parser (A5, addr, 4 data bytes MSB first[, XOR checksum]) issuing register writes; CMD_CHECKSUM_EN adds the checksum byte.
// Latency: wr_en rises 2 cycles after the stop-bit sample of the final frame byte.
// Backpressure: none; wr_en and err are single-cycle strobes that are never held off.
module uart_cmd_rx
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV    = 104,
    parameter int NUM_REGS    = 8,
    parameter int TIMEOUT_CYC = 120000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        rx,
    output logic        wr_en,
    output logic [3:0]  wr_addr,
    output logic [31:0] wr_data,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

    logic [7:0]     rx_byte;
    logic           byte_valid;
    logic           frame_err;
    parser_state_t  state;
    cmd_t           frame;
    logic [1:0]     dcnt;
    logic [TW-1:0]  tmo_cnt;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]     csum_acc;
`endif

    uart_rx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_rx_byte (
        .clk        (clk),
        .resetn     (resetn),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            frame    <= '0;
            dcnt     <= '0;
            tmo_cnt  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            err      <= 1'b0;
            err_code <= '0;
`ifdef CMD_CHECKSUM_EN
            csum_acc <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            err   <= 1'b0;
            if (state == ST_WRITE) begin
                // The next byte is at least a full character away, so no error can collide here.
                wr_en   <= 1'b1;
                wr_addr <= frame.addr;
                wr_data <= frame.data;
                state   <= ST_IDLE;
            end else if (frame_err) begin
                err      <= 1'b1;
                err_code <= ERR_FRAMING;
                state    <= ST_IDLE;
            end else if (byte_valid) begin
                tmo_cnt <= TW'(1);
                case (state)
                    ST_IDLE: begin
                        if (rx_byte == SYNC_BYTE) begin
                            state <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        frame.addr <= rx_byte[3:0];
`ifdef CMD_CHECKSUM_EN
                        csum_acc   <= rx_byte;
`endif
                        if (addr_ok(rx_byte, NUM_REGS)) begin
                            state <= ST_DATA;
                            dcnt  <= '0;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_ADDR;
                            state    <= ST_IDLE;
                        end
                    end
                    ST_DATA: begin
                        frame.data <= {frame.data[23:0], rx_byte};
`ifdef CMD_CHECKSUM_EN
                        csum_acc   <= csum_acc ^ rx_byte;
`endif
                        if (dcnt == 2'd3) begin
`ifdef CMD_CHECKSUM_EN
                            state <= ST_CSUM;
`else
                            state <= ST_WRITE;
`endif
                        end else begin
                            dcnt <= dcnt + 2'd1;
                        end
                    end
`ifdef CMD_CHECKSUM_EN
                    ST_CSUM: begin
                        if (rx_byte == csum_acc) begin
                            state <= ST_WRITE;
                        end else begin
                            err      <= 1'b1;
                            err_code <= ERR_CSUM;
                            state    <= ST_IDLE;
                        end
                    end
`endif
                    default: state <= ST_IDLE;
                endcase
            end else if (state != ST_IDLE) begin
                if (tmo_cnt == TMO_LAST) begin
                    err      <= 1'b1;
                    err_code <= ERR_TIMEOUT;
                    state    <= ST_IDLE;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx at BAUD_DIV=4, NUM_REGS=8, TIMEOUT_CYC=200; honours CMD_CHECKSUM_EN.
module tb_uart_cmd_rx;

    localparam int BAUD_DIV    = 4;
    localparam int NUM_REGS    = 8;
    localparam int TIMEOUT_CYC = 200;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        rx = 1'b1;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        err;
    logic [1:0]  err_code;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_cnt   = 0;
    int err_cnt  = 0;
    int overlap  = 0;

    uart_cmd_rx #(
        .BAUD_DIV    (BAUD_DIV),
        .NUM_REGS    (NUM_REGS),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .rx       (rx),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .err      (err),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (resetn) begin
            if (wr_en) wr_cnt++;
            if (err) err_cnt++;
            if (wr_en && err) overlap++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (BAUD_DIV) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BAUD_DIV) tick();
        end
        rx = stop;
        repeat (BAUD_DIV) tick();
        rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d);
        send_byte(8'hA5, 1'b1);
        send_byte(a, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8], 1'b1);
`ifdef CMD_CHECKSUM_EN
        send_byte(a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0], 1'b1);
`endif
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        rx = 1'b1;
        repeat (3) tick();
        if ({wr_en, err, busy} !== 3'b000) begin
            $display("FAIL reset_strobes: got %b want 000", {wr_en, err, busy});
            n_fail++;
        end
        n_checks++;
        if ({wr_addr, wr_data, err_code} !== 38'd0) begin
            $display("FAIL reset_regs: addr=%h data=%h code=%0d want all zero", wr_addr, wr_data, err_code);
            n_fail++;
        end
        n_checks++;
        resetn = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_write();
        int w0 = wr_cnt;
        int e0 = err_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hF4, 1'b1);
`ifdef CMD_CHECKSUM_EN
        send_byte(8'hF6, 1'b1);
`endif
        tick();
        tick();
        if (wr_en !== 1'b0) begin
            $display("FAIL write_early: wr_en=%b want 0", wr_en);
            n_fail++;
        end
        n_checks++;
        tick();
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd3, 32'h0000_01F4}) begin
            $display("FAIL write_strobe: en=%b addr=%h data=%h want 1/3/000001f4", wr_en, wr_addr, wr_data);
            n_fail++;
        end
        n_checks++;
        tick();
        if ({wr_en, busy} !== 2'b00) begin
            $display("FAIL write_one_cycle: en=%b busy=%b want 0 0", wr_en, busy);
            n_fail++;
        end
        n_checks++;
        if (wr_cnt - w0 !== 1 || err_cnt - e0 !== 0) begin
            $display("FAIL write_counts: writes=%0d errs=%0d want 1 0", wr_cnt - w0, err_cnt - e0);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_bad_addr();
        logic [7:0] bad [3] = '{8'h09, 8'h08, 8'h13};
        for (int k = 0; k < 3; k++) begin
            int w0 = wr_cnt;
            send_byte(8'hA5, 1'b1);
            send_byte(bad[k], 1'b1);
            tick();
            tick();
            if ({err, err_code, busy} !== {1'b1, 2'd1, 1'b0}) begin
                $display("FAIL bad_addr_%h: err=%b code=%0d busy=%b want 1 1 0", bad[k], err, err_code, busy);
                n_fail++;
            end
            n_checks++;
            send_byte(8'h00, 1'b1);
            send_byte(8'h00, 1'b1);
            send_byte(8'h01, 1'b1);
            send_byte(8'hF4, 1'b1);
            repeat (4) tick();
            if (wr_cnt !== w0) begin
                $display("FAIL bad_addr_nowrite_%h: writes=%0d want 0", bad[k], wr_cnt - w0);
                n_fail++;
            end
            n_checks++;
        end
    endtask

    task automatic test_frame_err();
        int w0 = wr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h55, 1'b0);
        tick();
        tick();
        if ({err, err_code, busy} !== {1'b1, 2'd0, 1'b0}) begin
            $display("FAIL frame_err: err=%b code=%0d busy=%b want 1 0 0", err, err_code, busy);
            n_fail++;
        end
        n_checks++;
        repeat (8) tick();
        send_frame(8'h06, 32'hDEAD_BEEF);
        repeat (4) tick();
        if (wr_cnt - w0 !== 1 || wr_addr !== 4'd6 || wr_data !== 32'hDEAD_BEEF) begin
            $display("FAIL frame_err_recover: writes=%0d addr=%h data=%h want 1/6/deadbeef", wr_cnt - w0, wr_addr, wr_data);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_timeout();
        int w0 = wr_cnt;
        int e0 = err_cnt;
        int first = -1;
        logic [1:0] code = 2'd0;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        for (int i = 1; i <= 250; i++) begin
            tick();
            if (err && first < 0) begin
                first = i;
                code  = err_code;
            end
        end
        // Stop sample lands 1 cycle after send_byte returns; strobe 1 later; error 200 after strobe.
        if (first !== 201 || code !== 2'd3) begin
            $display("FAIL timeout: at tick %0d code %0d want tick 201 code 3", first, code);
            n_fail++;
        end
        n_checks++;
        if (wr_cnt !== w0 || err_cnt - e0 !== 1 || busy !== 1'b0) begin
            $display("FAIL timeout_after: writes=%0d errs=%0d busy=%b want 0 1 0", wr_cnt - w0, err_cnt - e0, busy);
            n_fail++;
        end
        n_checks++;
    endtask

`ifdef CMD_CHECKSUM_EN
    task automatic test_checksum();
        int w0 = wr_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hF4, 1'b1);
        send_byte(8'h00, 1'b1);
        tick();
        tick();
        if ({err, err_code} !== {1'b1, 2'd2}) begin
            $display("FAIL checksum: err=%b code=%0d want 1 2", err, err_code);
            n_fail++;
        end
        n_checks++;
        repeat (4) tick();
        if (wr_cnt !== w0) begin
            $display("FAIL checksum_nowrite: writes=%0d want 0", wr_cnt - w0);
            n_fail++;
        end
        n_checks++;
    endtask
`endif

    task automatic test_glitch();
        int e0 = err_cnt;
        int w0 = wr_cnt;
        rx = 1'b0;
        tick();
        rx = 1'b1;
        repeat (30) tick();
        if (err_cnt !== e0 || busy !== 1'b0) begin
            $display("FAIL glitch: errs=%0d busy=%b want 0 0", err_cnt - e0, busy);
            n_fail++;
        end
        n_checks++;
        send_frame(8'h01, 32'h0000_0042);
        repeat (4) tick();
        if (wr_cnt - w0 !== 1 || wr_addr !== 4'd1 || wr_data !== 32'h42) begin
            $display("FAIL glitch_then_frame: writes=%0d addr=%h data=%h want 1/1/00000042", wr_cnt - w0, wr_addr, wr_data);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        int w0 = wr_cnt;
        send_byte(8'h5A, 1'b1);
        send_frame(8'h07, 32'hA5A5_A5A5);
        repeat (3) tick();
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd7, 32'hA5A5_A5A5}) begin
            $display("FAIL b2b_first: en=%b addr=%h data=%h want 1/7/a5a5a5a5", wr_en, wr_addr, wr_data);
            n_fail++;
        end
        n_checks++;
        send_frame(8'h05, 32'h1234_5678);
        repeat (3) tick();
        if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd5, 32'h1234_5678}) begin
            $display("FAIL b2b_second: en=%b addr=%h data=%h want 1/5/12345678", wr_en, wr_addr, wr_data);
            n_fail++;
        end
        n_checks++;
        repeat (30) tick();
        if ({wr_en, wr_addr, wr_data} !== {1'b0, 4'd5, 32'h1234_5678} || wr_cnt - w0 !== 2) begin
            $display("FAIL hold: en=%b addr=%h data=%h writes=%0d want 0/5/12345678/2", wr_en, wr_addr, wr_data, wr_cnt - w0);
            n_fail++;
        end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        int w0;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        rx = 1'b0;
        tick();
        resetn = 1'b0;
        #1;
        if ({wr_en, wr_addr, wr_data, err, err_code, busy} !== 40'd0) begin
            $display("FAIL reset_mid: en=%b addr=%h data=%h err=%b code=%0d busy=%b want all 0", wr_en, wr_addr, wr_data, err, err_code, busy);
            n_fail++;
        end
        n_checks++;
        rx = 1'b1;
        repeat (3) tick();
        resetn = 1'b1;
        repeat (3) tick();
        w0 = wr_cnt;
        send_byte(8'hF4, 1'b1);
        repeat (8) tick();
        if (wr_cnt !== w0) begin
            $display("FAIL reset_partial: writes=%0d want 0", wr_cnt - w0);
            n_fail++;
        end
        n_checks++;
        send_frame(8'h03, 32'h0000_01F4);
        repeat (4) tick();
        if (wr_cnt - w0 !== 1 || wr_addr !== 4'd3 || wr_data !== 32'h1F4) begin
            $display("FAIL reset_recover: writes=%0d addr=%h data=%h want 1/3/000001f4", wr_cnt - w0, wr_addr, wr_data);
            n_fail++;
        end
        n_checks++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_bad_addr();
        test_frame_err();
        test_timeout();
`ifdef CMD_CHECKSUM_EN
        test_checksum();
`endif
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        if (overlap !== 0) begin
            $display("FAIL err_wr_overlap: %0d cycles want 0", overlap);
            n_fail++;
        end
        n_checks++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 104, meaning clk cycles per UART bit (12 MHz / 115200), legal range 4..4095.
REQ-002 SHALL have parameter NUM_REGS, default 8, meaning number of writable pulse-parameter registers, legal range 1..16.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 120000, meaning idle clk cycles allowed between bytes inside one frame.
REQ-004 SHALL have port clk, input, 1, the single system clock.
REQ-005 SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rx, input, 1, asynchronous UART line (8N1, idle high), driven from RS232_Rx.
REQ-007 SHALL have port wr_en, output, 1, one-cycle strobe that commits a parameter write to pulse_gen.
REQ-008 SHALL have port wr_addr, output, 4, parameter register index; valid while wr_en=1.
REQ-009 SHALL have port wr_data, output, 32, parameter value; valid while wr_en=1.
REQ-010 SHALL have port err, output, 1, one-cycle error strobe.
REQ-011 SHALL have port err_code, output, 2, error cause: 0 framing, 1 bad address, 2 checksum, 3 timeout; valid while err=1.
REQ-012 SHALL have port busy, output, 1, high while parser is not in IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchroniser before any use.
REQ-014 Byte receiver SHALL detect start on a synchronised falling edge, recheck low at BAUD_DIV/2; if high, abandon silently (glitch).
REQ-015 Data bits SHALL be sampled LSB first at BAUD_DIV intervals from the start midpoint; stop bit sampled one interval after bit 7.
REQ-016 Stop bit low SHALL drop the byte, raise err with code 0, and force the parser to IDLE.
REQ-017 Byte-valid strobe SHALL be one cycle, issued in the cycle after the stop-bit sample.
REQ-018 Parser states: IDLE, ADDR, DATA, CSUM, WRITE.
REQ-019 IDLE: byte 0xA5 -> ADDR; any other byte ignored, no error.
REQ-020 ADDR: byte[3:0] latched as address; byte[7:4]!=0 or byte[3:0]>=NUM_REGS -> err code 1, IDLE; else DATA with data count 0.
REQ-021 DATA: four bytes shifted in MSB first; after the fourth -> CSUM (macro on) or WRITE (macro off).
REQ-022 WRITE: wr_en=1 for exactly one cycle with wr_addr/wr_data, then IDLE; latency from stop-bit sample of last frame byte to wr_en = 2 cycles.
REQ-023 wr_addr/wr_data SHALL hold last written values between strobes.
REQ-024 In ADDR/DATA/CSUM, TIMEOUT_CYC cycles with no byte-valid strobe -> err code 3, IDLE; counter restarts on each byte.
REQ-025 0xA5 received in ADDR/DATA/CSUM SHALL be treated as data, not resync.
REQ-026 err and wr_en SHALL never assert in the same cycle.
REQ-027 busy SHALL be low exactly when parser state is IDLE.

Reset
REQ-028 resetn low SHALL asynchronously clear: wr_en=0, wr_addr=0, wr_data=0, err=0, err_code=0, busy=0, parser IDLE, byte receiver idle, synchroniser flops=1.
REQ-029 Reset mid-frame or mid-byte SHALL discard partial data; no wr_en issued after release until a complete new frame.

Configuration
REQ-030 Macro CMD_CHECKSUM_EN defined: CSUM state present; expected byte = XOR of address byte and four data bytes; mismatch -> err code 2, IDLE, no write.
REQ-031 Macro CMD_CHECKSUM_EN undefined: CSUM state and checksum logic absent; frame is 6 bytes; err code 2 never produced.

Structure
REQ-032 Shared package uart_cmd_pkg SHALL hold the sync byte 0xA5, the parser state enum, and err_code constants.
REQ-033 Byte receiver SHALL be sub-module uart_rx_byte (clk, resetn, rx, BAUD_DIV -> byte, byte_valid, frame_err); parser stays in uart_cmd_rx.

Verification (BAUD_DIV=4, NUM_REGS=8, TIMEOUT_CYC=200)
REQ-034 Frame A5 03 00 00 01 F4 [+csum F4^01^03=F6] -> one wr_en, wr_addr=3, wr_data=0x000001F4, err never high.
REQ-035 Frame A5 09 ... -> err=1 code 1 after address byte, no wr_en, busy low next cycle.
REQ-036 Byte with stop bit low mid-frame -> err code 0, IDLE; following valid frame writes correctly.
REQ-037 A5 02 then 250 idle cycles -> err code 3 at cycle 200 after byte strobe, no wr_en.
REQ-038 Macro on, checksum 00 on frame of REQ-034 -> err code 2, no wr_en; 1-cycle low rx glitch in IDLE -> no byte, no error.
REQ-039 resetn asserted after third data byte -> all outputs 0 immediately; full frame after release writes once.
